pll_lock_reset_sequencer: RTL and testbench

Single-clock supervisor that sits between one or more PLL primitives and the rest of the design. It synchronises the PLLs' asynchronous `locked` outputs, requires a stable lock before releasing per-domain resets in a staggered order (SDRAM controller first, then CPU, then peripherals), and pulses the PLL reset on lock timeout or lock loss. It also counts lock-loss events for debug.

---
 rtl/clk_rst_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_reset_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_reset_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared state encoding and saturating-count helpers for the PLL reset sequencer
package clk_rst_pkg;

  typedef enum logic [2:0] {
    RESTART   = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int SAT_CNT_W = 8;

  function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] v);
    return (v == {SAT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser, async active-high reset to 0
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// rtl/pll_lock_reset_sequencer.sv - waits for stable PLL lock, releases domain resets in staggered order
module pll_lock_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_PLLS       = 2,
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int RESTART_PULSE  = 8,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_PLLS-1:0]    locked_in,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_ready,
  output logic [SAT_CNT_W-1:0]   loss_count,
  output logic [SAT_CNT_W-1:0]   retry_count
);

  localparam int REL_SPAN = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int MAX_AB   = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD   = (RESTART_PULSE > REL_SPAN) ? RESTART_PULSE : REL_SPAN;
  localparam int MAX_ALL  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW       = $clog2(MAX_ALL) + 1;
  localparam int IW       = $clog2(NUM_DOMAINS + 1);

  // The WAIT_LOCK cycle that first sees lock counts as the first hold cycle.
  localparam int HOLD_LAST_I = (HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0;

  localparam logic [CW-1:0] RESTART_LAST = CW'(RESTART_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_LAST_I);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_DONE     = IW'(NUM_DOMAINS);

  logic [NUM_PLLS-1:0] lk_s;
  logic                all_lk;

  for (genvar g = 0; g < NUM_PLLS; g++) begin : g_sync
    sync_2ff u_sync (
      .clock (clock),
      .reset (reset),
      .d     (locked_in[g]),
      .q     (lk_s[g])
    );
  end

  assign all_lk = &lk_s;

  seq_state_t             state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [NUM_DOMAINS-1:0] dr_n;
  logic [SAT_CNT_W-1:0]   loss_n, retry_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RESTART;
      cnt          <= '0;
      idx          <= '0;
      domain_reset <= '1;
      pll_rst      <= 1'b1;
      all_ready    <= 1'b0;
      loss_count   <= '0;
      retry_count  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      domain_reset <= dr_n;
      pll_rst      <= (state_n == RESTART);
      all_ready    <= (state_n == RUN);
      loss_count   <= loss_n;
      retry_count  <= retry_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    dr_n    = domain_reset;
    loss_n  = loss_count;
    retry_n = retry_count;
    case (state)
      RESTART: begin
        if (cnt == RESTART_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        if (all_lk) begin
          cnt_n = '0;
          if (HOLD_CYCLES == 1) begin
            state_n = RELEASE;
            dr_n    = domain_reset << 1;
            idx_n   = IW'(1);
          end else begin
            state_n = HOLD;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_n = RESTART;
          cnt_n   = '0;
          retry_n = sat_inc(retry_count);
        end
      end
      HOLD: begin
        if (!all_lk) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n = RELEASE;
          cnt_n   = '0;
          dr_n    = domain_reset << 1;
          idx_n   = IW'(1);
        end
      end
      RELEASE: begin
        if (!all_lk) begin
          state_n = RESTART;
          cnt_n   = '0;
          idx_n   = '0;
          dr_n    = '1;
          loss_n  = sat_inc(loss_count);
        end else if (cnt == STAGGER_LAST) begin
          cnt_n = '0;
          if (idx == IDX_DONE) begin
            state_n = RUN;
          end else begin
            dr_n  = domain_reset << 1;
            idx_n = idx + 1'b1;
          end
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!all_lk) begin
          state_n = RESTART;
          idx_n   = '0;
          dr_n    = '1;
          loss_n  = sat_inc(loss_count);
        end
      end
      default: begin
        state_n = RESTART;
        cnt_n   = '0;
        idx_n   = '0;
        dr_n    = '1;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb/tb_pll_lock_reset_sequencer.sv - directed bench for pll_lock_reset_sequencer
module tb_pll_lock_reset_sequencer;

  logic       clock;
  logic       reset;
  logic [1:0] locked_in;
  logic       pll_rst;
  logic [2:0] domain_reset;
  logic       all_ready;
  logic [7:0] loss_count;
  logic [7:0] retry_count;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  pll_lock_reset_sequencer #(
    .NUM_PLLS       (2),
    .NUM_DOMAINS    (3),
    .HOLD_CYCLES    (8),
    .STAGGER_CYCLES (4),
    .RESTART_PULSE  (3),
    .LOCK_TIMEOUT   (20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .locked_in    (locked_in),
    .pll_rst      (pll_rst),
    .domain_reset (domain_reset),
    .all_ready    (all_ready),
    .loss_count   (loss_count),
    .retry_count  (retry_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
    cyc++;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    locked_in = 2'b00;
    @(posedge clock);
    #2;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    reset     = 1'b0;
    locked_in = 2'b00;
    #1 reset = 1'b1;
    #2;
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_domain_reset", 32'(domain_reset), 32'h7);
    check("rst_all_ready", 32'(all_ready), 32'd0);
    check("rst_loss", 32'(loss_count), 32'd0);
    check("rst_retry", 32'(retry_count), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    cyc   = 0;

    // clean bring-up
    check("up_pll_rst_c0", 32'(pll_rst), 32'd1);
    step_to(2);  check("up_pll_rst_c2", 32'(pll_rst), 32'd1);
    step_to(3);  check("up_pll_rst_c3", 32'(pll_rst), 32'd0);
    step_to(10); locked_in = 2'b11;
    step_to(19); check("up_dr_c19", 32'(domain_reset), 32'h7);
    step_to(20); check("up_dr_c20", 32'(domain_reset), 32'h6);
    step_to(23); check("up_dr_c23", 32'(domain_reset), 32'h6);
    step_to(24); check("up_dr_c24", 32'(domain_reset), 32'h4);
    step_to(27); check("up_dr_c27", 32'(domain_reset), 32'h4);
    step_to(28); check("up_dr_c28", 32'(domain_reset), 32'h0);
    step_to(31); check("up_ready_c31", 32'(all_ready), 32'd0);
    step_to(32); check("up_ready_c32", 32'(all_ready), 32'd1);
    check("up_pll_rst_c32", 32'(pll_rst), 32'd0);

    // loss in RUN
    step_to(40); locked_in = 2'b10;
    step_to(42); check("loss_dr_c42", 32'(domain_reset), 32'h0);
    check("loss_ready_c42", 32'(all_ready), 32'd1);
    step_to(43); check("loss_dr_c43", 32'(domain_reset), 32'h7);
    check("loss_ready_c43", 32'(all_ready), 32'd0);
    check("loss_count_c43", 32'(loss_count), 32'd1);
    check("loss_pll_rst_c43", 32'(pll_rst), 32'd1);
    step_to(45); check("loss_pll_rst_c45", 32'(pll_rst), 32'd1);
    step_to(46); check("loss_pll_rst_c46", 32'(pll_rst), 32'd0);
    locked_in = 2'b11;
    step_to(55); check("relock_dr_c55", 32'(domain_reset), 32'h7);
    step_to(56); check("relock_dr_c56", 32'(domain_reset), 32'h6);
    step_to(60); check("relock_dr_c60", 32'(domain_reset), 32'h4);
    step_to(64); check("relock_dr_c64", 32'(domain_reset), 32'h0);
    step_to(67); check("relock_ready_c67", 32'(all_ready), 32'd0);
    step_to(68); check("relock_ready_c68", 32'(all_ready), 32'd1);
    check("relock_loss", 32'(loss_count), 32'd1);

    // glitch during HOLD
    do_reset();
    check("glitch_loss_cleared", 32'(loss_count), 32'd0);
    step_to(10); locked_in = 2'b11;
    step_to(16); locked_in = 2'b01;
    step_to(17); locked_in = 2'b11;
    step_to(20); check("glitch_dr_c20", 32'(domain_reset), 32'h7);
    step_to(26); check("glitch_dr_c26", 32'(domain_reset), 32'h7);
    step_to(27); check("glitch_dr_c27", 32'(domain_reset), 32'h6);
    step_to(31); check("glitch_dr_c31", 32'(domain_reset), 32'h4);
    step_to(35); check("glitch_dr_c35", 32'(domain_reset), 32'h0);
    step_to(38); check("glitch_ready_c38", 32'(all_ready), 32'd0);
    step_to(39); check("glitch_ready_c39", 32'(all_ready), 32'd1);
    check("glitch_loss", 32'(loss_count), 32'd0);

    // partial lock
    do_reset();
    locked_in = 2'b01;
    step_to(22); check("part_pll_rst_c22", 32'(pll_rst), 32'd0);
    check("part_retry_c22", 32'(retry_count), 32'd0);
    step_to(23); check("part_pll_rst_c23", 32'(pll_rst), 32'd1);
    check("part_retry_c23", 32'(retry_count), 32'd1);
    step_to(25); check("part_pll_rst_c25", 32'(pll_rst), 32'd1);
    step_to(26); check("part_pll_rst_c26", 32'(pll_rst), 32'd0);
    step_to(45); check("part_pll_rst_c45", 32'(pll_rst), 32'd0);
    step_to(46); check("part_pll_rst_c46", 32'(pll_rst), 32'd1);
    check("part_retry_c46", 32'(retry_count), 32'd2);
    step_to(69); check("part_retry_c69", 32'(retry_count), 32'd3);
    check("part_dr_c69", 32'(domain_reset), 32'h7);
    check("part_ready_c69", 32'(all_ready), 32'd0);

    // saturation of loss_count
    do_reset();
    locked_in = 2'b11;
    for (int i = 0; i < 260; i++) begin
      int n;
      n = 0;
      while (all_ready !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) begin
        check("sat_ready_timeout", 32'(all_ready), 32'd1);
        break;
      end
      locked_in = 2'b00;
      n = 0;
      while (pll_rst !== 1'b1 && n < 10) begin step(); n++; end
      if (n >= 10) begin
        check("sat_loss_timeout", 32'(pll_rst), 32'd1);
        break;
      end
      locked_in = 2'b11;
      if (i == 99)  check("sat_loss_100", 32'(loss_count), 32'd100);
      if (i == 254) check("sat_loss_255", 32'(loss_count), 32'd255);
    end
    check("sat_loss_260", 32'(loss_count), 32'd255);

    // async reset mid-RELEASE
    begin
      int n;
      n = 0;
      while (domain_reset !== 3'b100 && n < 100) begin step(); n++; end
      check("arst_reach_100", 32'(domain_reset), 32'h4);
      #1 reset = 1'b1;
      #1;
      check("arst_dr", 32'(domain_reset), 32'h7);
      check("arst_pll_rst", 32'(pll_rst), 32'd1);
      check("arst_ready", 32'(all_ready), 32'd0);
      check("arst_loss", 32'(loss_count), 32'd0);
      check("arst_retry", 32'(retry_count), 32'd0);
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
